// File: rtl/dfr_pkg.sv
// Shared types and helpers for the DFR readout stage.
// DFR_OUTPUT_SAT_EN selects saturating narrowing in dfr_scale instead of plain truncation.
package dfr_pkg;

  localparam int DFR_DATA_WIDTH = 32;
  localparam int DFR_ACC_WIDTH  = 64;
  localparam int DFR_FRAC_BITS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dfr_out_state_t;

  // Narrows an already arithmetically shifted accumulator to the output width.
  function automatic logic [DFR_DATA_WIDTH-1:0] dfr_scale(
    input logic signed [DFR_ACC_WIDTH-1:0] shifted
  );
    logic [DFR_DATA_WIDTH-1:0] result;
`ifdef DFR_OUTPUT_SAT_EN
    logic [DFR_ACC_WIDTH-DFR_DATA_WIDTH:0] upper;
    upper = shifted[DFR_ACC_WIDTH-1:DFR_DATA_WIDTH-1];
    if ((&upper) || !(|upper)) begin
      result = shifted[DFR_DATA_WIDTH-1:0];
    end else if (shifted[DFR_ACC_WIDTH-1]) begin
      result = {1'b1, {(DFR_DATA_WIDTH-1){1'b0}}};
    end else begin
      result = {1'b0, {(DFR_DATA_WIDTH-1){1'b1}}};
    end
`else
    result = shifted[DFR_DATA_WIDTH-1:0];
`endif
    return result;
  endfunction

endpackage

// File: rtl/dfr_output_layer_mac.sv
// dfr_mac_unit: signed multiply-accumulate with synchronous clear and a scaled readout.
// Scaling honours DFR_OUTPUT_SAT_EN through dfr_pkg::dfr_scale.
module dfr_mac_unit
  import dfr_pkg::*;
#(
  parameter int DATA_WIDTH = DFR_DATA_WIDTH,
  parameter int ACC_WIDTH  = DFR_ACC_WIDTH,
  parameter int FRAC_BITS  = DFR_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] scaled
);

  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]    acc_r;
  logic signed [ACC_WIDTH-1:0]    shifted_s;

  assign prod_s    = $signed(a) * $signed(b);
  assign shifted_s = acc_r >>> FRAC_BITS;
  assign scaled    = dfr_scale(shifted_s);

  // Accumulator: clear wins over a qualified product; wraps at ACC_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (valid) begin
      acc_r <= acc_r + ACC_WIDTH'(prod_s);
    end
  end

endmodule

// File: rtl/dfr_output_layer.sv
// dfr_output_layer: per-sample linear readout y[s] = sum_n x[s][n]*w[n], one node per cycle.
// Define DFR_OUTPUT_SAT_EN to saturate the scaled result instead of truncating it.
module dfr_output_layer
  import dfr_pkg::*;
#(
  parameter int NUM_VIRTUAL_NODES            = 100,
  parameter int DATA_WIDTH                   = DFR_DATA_WIDTH,
  parameter int ACC_WIDTH                    = DFR_ACC_WIDTH,
  parameter int FRAC_BITS                    = DFR_FRAC_BITS,
  parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 16,
  parameter int WEIGHT_ADDR_WIDTH            = 7,
  parameter int OUTPUT_ADDR_WIDTH            = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [31:0]                             num_samples,
  output logic                                    busy,
  output logic                                    done,
  output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] res_addr,
  input  logic [DATA_WIDTH-1:0]                   res_data,
  output logic [WEIGHT_ADDR_WIDTH-1:0]            weight_addr,
  input  logic [DATA_WIDTH-1:0]                   weight_data,
  output logic                                    out_we,
  output logic [OUTPUT_ADDR_WIDTH-1:0]            out_addr,
  output logic [DATA_WIDTH-1:0]                   out_data
);

  localparam int NW = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(NUM_VIRTUAL_NODES - 1);
  localparam logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] N_STEP =
    RESERVOIR_HISTORY_ADDR_WIDTH'(NUM_VIRTUAL_NODES);

  dfr_out_state_t state_r, next_state_s;

  logic [NW-1:0]                           n_r;
  logic [31:0]                             s_r;
  logic [31:0]                             num_r;
  logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] base_r;
  logic                                    rd_valid_r;
  logic                                    busy_r, done_r, out_we_r;
  logic [OUTPUT_ADDR_WIDTH-1:0]            out_addr_r;
  logic [DATA_WIDTH-1:0]                   mac_scaled_s;
  logic                                    mac_clr_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a start seen outside IDLE is deliberately dropped.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = (num_samples != 32'd0) ? ST_RUN : ST_DONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (n_r == N_LAST) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DRAIN: next_state_s = ST_WRITE;
      ST_WRITE: begin
        if ((s_r + 32'd1) == num_r) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Node/sample counters and the running history base address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r    <= '0;
      s_r    <= 32'd0;
      num_r  <= 32'd0;
      base_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            num_r  <= num_samples;
            s_r    <= 32'd0;
            n_r    <= '0;
            base_r <= '0;
          end
        end
        ST_RUN: begin
          if (n_r != N_LAST) begin
            n_r <= n_r + NW'(1);
          end
        end
        ST_WRITE: begin
          n_r    <= '0;
          s_r    <= s_r + 32'd1;
          base_r <= base_r + N_STEP;
        end
        default: ;
      endcase
    end
  end

  // Read data returns one cycle after the address, so the qualifier lags RUN by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= (state_r == ST_RUN);
    end
  end

  // Handshake and write-port outputs, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      out_we_r   <= 1'b0;
      out_addr_r <= '0;
    end else begin
      busy_r     <= (next_state_s == ST_RUN) || (next_state_s == ST_DRAIN) ||
                    (next_state_s == ST_WRITE);
      done_r     <= (next_state_s == ST_DONE);
      out_we_r   <= (next_state_s == ST_WRITE);
      out_addr_r <= (next_state_s == ST_WRITE) ? OUTPUT_ADDR_WIDTH'(s_r) : '0;
    end
  end

  assign mac_clr_s = (state_r == ST_WRITE);

  dfr_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr_s),
    .valid  (rd_valid_r),
    .a      (res_data),
    .b      (weight_data),
    .scaled (mac_scaled_s)
  );

  assign busy        = busy_r;
  assign done        = done_r;
  assign out_we      = out_we_r;
  assign out_addr    = out_addr_r;
  assign out_data    = out_we_r ? mac_scaled_s : '0;
  assign res_addr    = (state_r == ST_RUN) ?
                       (base_r + RESERVOIR_HISTORY_ADDR_WIDTH'(n_r)) : '0;
  assign weight_addr = (state_r == ST_RUN) ? WEIGHT_ADDR_WIDTH'(n_r) : '0;

endmodule

// File: tb/tb_dfr_output_layer.sv
// Randomized self-checking bench for dfr_output_layer against a cycle-indexed behavioural model.
`timescale 1ns/1ps
module tb_dfr_output_layer;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int WAW   = 7;
  localparam int OAW   = 16;
  localparam int DEPTH = 1 << AW;
  localparam int PER   = N + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [31:0]    num_samples = 32'd0;
  logic           busy, done, out_we;
  logic [AW-1:0]  res_addr;
  logic [WAW-1:0] weight_addr;
  logic [DW-1:0]  res_data, weight_data, out_data;
  logic [OAW-1:0] out_addr;

  logic [DW-1:0] res_mem    [DEPTH];
  logic [DW-1:0] weight_mem [128];

  int compared = 0;
  int mismatched = 0;

  bit            running = 1'b0;
  int            k = 0;
  int            run_s = 0;
  int            run_end = 0;
  logic [DW-1:0] exp_y [$];
  logic [DW-1:0] cap [16];
  int            busy_cnt = 0, done_cnt = 0, we_cnt = 0;

  dfr_output_layer #(
    .NUM_VIRTUAL_NODES            (N),
    .RESERVOIR_HISTORY_ADDR_WIDTH (AW),
    .WEIGHT_ADDR_WIDTH            (WAW),
    .OUTPUT_ADDR_WIDTH            (OAW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .busy        (busy),
    .done        (done),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .out_we      (out_we),
    .out_addr    (out_addr),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories feeding the DUT.
  always @(posedge clk) begin
    res_data    <= res_mem[res_addr];
    weight_data <= weight_mem[weight_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_scale(input longint acc);
    longint sh;
    sh = acc >>> 16;
`ifdef DFR_OUTPUT_SAT_EN
    if (sh > 64'sd2147483647) return 32'h7FFFFFFF;
    if (sh < -64'sd2147483648) return 32'h80000000;
`endif
    return sh[31:0];
  endfunction

  function automatic logic [DW-1:0] sample_y(input int s);
    longint acc;
    acc = 0;
    for (int n = 0; n < N; n++) begin
      acc += longint'($signed(res_mem[(s * N + n) % DEPTH])) *
             longint'($signed(weight_mem[n]));
    end
    return model_scale(acc);
  endfunction

  // Single compare process: expectations come from the cycle index since the accepted start.
  always @(negedge clk) begin
    int  j, p;
    bit  e_busy, e_done, e_we, e_addr;
    int  e_ra, e_wa, e_oa;
    logic [DW-1:0] e_od;
    if (rst) begin
      running = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", out_we, 0);
      chk("rst_data", out_data, 0);
      chk("rst_oaddr", out_addr, 0);
    end else begin
      if (running) k++;
      e_busy = 0; e_done = 0; e_we = 0; e_addr = 0;
      e_ra = 0; e_wa = 0; e_oa = 0; e_od = '0;
      if (running) begin
        if (run_s == 0) begin
          e_done = (k == 1);
        end else if (k >= 1 && k <= run_s * PER) begin
          j = (k - 1) / PER;
          p = (k - 1) % PER;
          e_busy = 1;
          if (p < N) begin
            e_addr = 1; e_ra = (j * N + p) % DEPTH; e_wa = p;
          end
          if (p == N + 1) begin
            e_we = 1; e_oa = j; e_od = exp_y[j];
          end
        end else if (k == run_end) begin
          e_done = 1;
        end
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("out_we", out_we, e_we);
      if (e_addr) begin
        chk("res_addr", res_addr, e_ra);
        chk("weight_addr", weight_addr, e_wa);
      end
      if (e_we) begin
        chk("out_addr", out_addr, e_oa);
        chk("out_data", out_data, e_od);
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (out_we) begin
        we_cnt++;
        cap[out_addr[3:0]] = out_data;
      end
      if (running && k > run_end) running = 1'b0;
      if (start && !running) begin
        running = 1'b1;
        k = 0;
        run_s = int'(num_samples);
        run_end = (run_s == 0) ? 1 : run_s * PER + 1;
        exp_y.delete();
        for (int s = 0; s < run_s; s++) exp_y.push_back(sample_y(s));
        busy_cnt = 0; done_cnt = 0; we_cnt = 0;
      end
    end
  end

  task automatic pulse_start(input int ns);
    @(posedge clk); #1;
    start = 1'b1;
    num_samples = ns;
    @(posedge clk); #1;
    start = 1'b0;
    num_samples = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (running && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) begin
      mismatched++;
      $display("FAIL wait_idle: run still active after %0d cycles", t);
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < N; i++) begin
      res_mem[i]    = (i + 1) << 16;
      weight_mem[i] = 32'h00010000;
    end
  endtask

  initial begin
    logic [DW-1:0] ovf_exp;
    int t;
    for (int i = 0; i < DEPTH; i++) res_mem[i] = '0;
    for (int i = 0; i < 128; i++) weight_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic dot product.
    load_basic();
    pulse_start(1);
    wait_idle();
    chk("basic_y", cap[0], 32'h000A0000);
    chk("basic_we_cnt", we_cnt, 1);
    chk("basic_done_cnt", done_cnt, 1);

    // Sign handling.
    for (int i = 0; i < N; i++) begin
      res_mem[i] = 32'h00020000;
      weight_mem[i] = 32'hFFFF0000;
    end
    pulse_start(1);
    wait_idle();
    chk("sign_y", cap[0], 32'hFFF80000);

    // Timing and addressing over three samples.
    for (int i = 0; i < DEPTH; i++) res_mem[i] = $urandom_range(0, 32'h000FFFFF);
    for (int i = 0; i < N; i++) weight_mem[i] = $urandom_range(0, 32'h0003FFFF);
    pulse_start(3);
    wait_idle();
    chk("timing_busy_cnt", busy_cnt, 18);
    chk("timing_we_cnt", we_cnt, 3);
    chk("timing_done_cnt", done_cnt, 1);

    // Empty run.
    pulse_start(0);
    wait_idle();
    chk("empty_busy_cnt", busy_cnt, 0);
    chk("empty_we_cnt", we_cnt, 0);
    chk("empty_done_cnt", done_cnt, 1);

    // Accumulator overflow.
    for (int i = 0; i < N; i++) begin
      res_mem[i] = 32'h40000000;
      weight_mem[i] = 32'h40000000;
    end
`ifdef DFR_OUTPUT_SAT_EN
    ovf_exp = 32'h7FFFFFFF;
`else
    ovf_exp = 32'h00000000;
`endif
    cap[0] = 32'hDEADBEEF;
    pulse_start(1);
    wait_idle();
    chk("overflow_y", cap[0], ovf_exp);

    // Reset during sample 1, then a clean rerun.
    load_basic();
    pulse_start(3);
    t = 0;
    while (k < PER + 2 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", out_we, 0);
    chk("midrst_done", done, 0);
    chk("midrst_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (PER + 2) @(posedge clk);
    cap[0] = '0;
    pulse_start(1);
    wait_idle();
    chk("rerun_y", cap[0], 32'h000A0000);

    // Randomized runs with stray start pulses and num_samples changes mid-run.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < DEPTH; i++) res_mem[i] = $urandom;
      for (int i = 0; i < N; i++) weight_mem[i] = $urandom;
      if (it % 3 == 0) begin
        for (int i = 0; i < DEPTH; i++) res_mem[i] = $urandom_range(0, 32'h0001FFFF) - 32'h00010000;
      end
      pulse_start($urandom_range(0, 6));
      repeat ($urandom_range(1, 12)) @(posedge clk);
      if ($urandom_range(0, 1) == 1) pulse_start($urandom_range(1, 3));
      wait_idle();
      chk("rand_we_cnt", we_cnt, run_s);
      chk("rand_busy_cnt", busy_cnt, run_s * PER);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
